// File: rtl/display_writer.sv
// display_writer: character-to-framebuffer writer for a COLS x ROWS text screen.
// Accepts ASCII codes one at a time. It prints printable codes at the cursor and
// interprets LF, CR and BS. It scrolls the screen up one row when output runs
// past the last row, and blanks the whole screen on a clear request.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_char   character offer (7-bit ASCII)
//   in_ready            combinational accept indication (IDLE and no clear pending)
//   clear_req           level request to blank the screen and home the cursor
//   buf_we/addr/wdata   registered display buffer write port
//   buf_rdata           display buffer read data for the address currently driven
//   cursor_row/col      current cursor position
//   busy                high whenever the writer is not IDLE
module display_writer #(
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 30,
  parameter int unsigned MEM_SIZE = 2400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  in_char,
  output logic        in_ready,
  input  logic        clear_req,
  output logic        buf_we,
  output logic [11:0] buf_addr,
  output logic [6:0]  buf_wdata,
  input  logic [6:0]  buf_rdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam int unsigned AW = 12;

  localparam logic [6:0]    CH_SPACE    = 7'h20;
  localparam logic [6:0]    CH_TILDE    = 7'h7E;
  localparam logic [6:0]    CH_LF       = 7'h0A;
  localparam logic [6:0]    CH_CR       = 7'h0D;
  localparam logic [6:0]    CH_BS       = 7'h08;
  localparam logic [AW-1:0] SRC_START   = AW'(COLS);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(MEM_SIZE - 1);
  localparam logic [AW-1:0] BLANK_START = AW'(MEM_SIZE - COLS);
  localparam logic [4:0]    LAST_ROW    = 5'(ROWS - 1);
  localparam logic [6:0]    LAST_COL    = 7'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCROLL_RD,
    SCROLL_WR,
    BLANK,
    CLEAR
  } state_t;

  state_t        state;
  logic [AW-1:0] src;           // scroll source address
  logic          scroll_after;  // the pending WRITE wrapped off the last row

  // Cursor address row*80+col using shifts; assumes the 80-column layout.
  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [AW-1:0] r;
    r = AW'(row);
    return (r << 6) + (r << 4) + AW'(col);
  endfunction

  logic printable;
  assign printable = (in_char >= CH_SPACE) && (in_char <= CH_TILDE);

  assign in_ready = (state == IDLE) && !clear_req;

  // Writer FSM; buffer port, cursor and busy are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cursor_row   <= 5'd0;
      cursor_col   <= 7'd0;
      src          <= SRC_START;
      scroll_after <= 1'b0;
      buf_we       <= 1'b0;
      buf_addr     <= '0;
      buf_wdata    <= 7'd0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            buf_we    <= 1'b1;
            buf_addr  <= '0;
            buf_wdata <= CH_SPACE;
          end else if (in_valid) begin
            if (printable) begin
              state     <= WRITE;
              busy      <= 1'b1;
              buf_we    <= 1'b1;
              buf_addr  <= cell_addr(cursor_row, cursor_col);
              buf_wdata <= in_char;
              if (cursor_col == LAST_COL) begin
                cursor_col <= 7'd0;
                if (cursor_row == LAST_ROW) scroll_after <= 1'b1;
                else                        cursor_row   <= cursor_row + 5'd1;
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end else if (in_char == CH_LF) begin
              cursor_col <= 7'd0;
              if (cursor_row == LAST_ROW) begin
                state    <= SCROLL_RD;
                busy     <= 1'b1;
                buf_addr <= src;
              end else begin
                cursor_row <= cursor_row + 5'd1;
                buf_addr   <= cell_addr(cursor_row + 5'd1, 7'd0);
              end
            end else if (in_char == CH_CR) begin
              cursor_col <= 7'd0;
              buf_addr   <= cell_addr(cursor_row, 7'd0);
            end else if ((in_char == CH_BS) && (cursor_col != 7'd0)) begin
              state      <= WRITE;
              busy       <= 1'b1;
              buf_we     <= 1'b1;
              cursor_col <= cursor_col - 7'd1;
              buf_addr   <= cell_addr(cursor_row, cursor_col - 7'd1);
              buf_wdata  <= CH_SPACE;
            end
          end
        end

        WRITE: begin
          buf_we       <= 1'b0;
          scroll_after <= 1'b0;
          if (scroll_after) begin
            state    <= SCROLL_RD;
            buf_addr <= src;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            buf_addr <= cell_addr(cursor_row, cursor_col);
          end
        end

        // Read data for src arrives while SCROLL_RD is driven; capture it as
        // the write data for the row above.
        SCROLL_RD: begin
          state     <= SCROLL_WR;
          buf_we    <= 1'b1;
          buf_addr  <= src - SRC_START;
          buf_wdata <= buf_rdata;
        end

        SCROLL_WR: begin
          if (src == LAST_ADDR) begin
            state     <= BLANK;
            src       <= SRC_START;
            buf_addr  <= BLANK_START;
            buf_wdata <= CH_SPACE;
          end else begin
            state    <= SCROLL_RD;
            src      <= src + 12'd1;
            buf_we   <= 1'b0;
            buf_addr <= src + 12'd1;
          end
        end

        // Blank the freshly exposed bottom row; buf_addr doubles as the counter.
        BLANK: begin
          if (buf_addr == LAST_ADDR) begin
            state    <= IDLE;
            busy     <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= cell_addr(cursor_row, cursor_col);
          end else begin
            buf_addr <= buf_addr + 12'd1;
          end
        end

        CLEAR: begin
          if (buf_addr == LAST_ADDR) begin
            state      <= IDLE;
            busy       <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            cursor_row <= 5'd0;
            cursor_col <= 7'd0;
          end else begin
            buf_addr <= buf_addr + 12'd1;
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          buf_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_writer.sv
// tb_display_writer: self-checking bench for display_writer. It models the screen as a
// plain array plus an expected-write queue built from the character rules. A
// negedge monitor checks every buffer write and the idle cursor against it.
module tb_display_writer;

  localparam int COLS       = 80;
  localparam int ROWS       = 30;
  localparam int MEM        = 2400;
  localparam int SCROLL_CYC = 2 * (MEM - COLS) + COLS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  in_char = 7'd0;
  logic        clear_req = 1'b0;
  logic        in_ready;
  logic        buf_we;
  logic [11:0] buf_addr;
  logic [6:0]  buf_wdata;
  logic [6:0]  buf_rdata;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [6:0]  mem     [MEM];
  logic [6:0]  ref_mem [MEM];
  logic [18:0] expq [$];
  int          exp_row = 0;
  int          exp_col = 0;
  int          exp_dur = 0;
  bit          chk_en  = 1'b0;

  always #5 clk = ~clk;

  display_writer #(.COLS(COLS), .ROWS(ROWS), .MEM_SIZE(MEM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .clear_req  (clear_req),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .buf_rdata  (buf_rdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  // Display buffer: read data follows the driven address, writes land on the edge.
  assign buf_rdata = (int'(buf_addr) < MEM) ? mem[buf_addr] : 7'd0;

  initial begin
    for (int i = 0; i < MEM; i++) mem[i] = 7'd0;
    forever begin
      @(posedge clk);
      if (rst_n && buf_we && int'(buf_addr) < MEM) mem[buf_addr] <= buf_wdata;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_wr(input int a, input int d);
    expq.push_back({12'(a), 7'(d)});
    ref_mem[a] = 7'(d);
  endtask

  task automatic model_scroll();
    for (int a = 0; a < MEM - COLS; a++) push_wr(a, int'(ref_mem[a + COLS]));
    for (int a = MEM - COLS; a < MEM; a++) push_wr(a, 32'h20);
  endtask

  task automatic model_accept(input logic [6:0] ch);
    exp_dur = 0;
    if (ch >= 7'h20 && ch <= 7'h7E) begin
      push_wr(exp_row * COLS + exp_col, int'(ch));
      exp_dur = 1;
      exp_col++;
      if (exp_col == COLS) begin
        exp_col = 0;
        if (exp_row == ROWS - 1) begin
          model_scroll();
          exp_dur += SCROLL_CYC;
        end else exp_row++;
      end
    end else if (ch == 7'h0A) begin
      exp_col = 0;
      if (exp_row == ROWS - 1) begin
        model_scroll();
        exp_dur = SCROLL_CYC;
      end else exp_row++;
    end else if (ch == 7'h0D) begin
      exp_col = 0;
    end else if (ch == 7'h08 && exp_col > 0) begin
      exp_col--;
      push_wr(exp_row * COLS + exp_col, 32'h20);
      exp_dur = 1;
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < MEM; a++) push_wr(a, 32'h20);
    exp_row = 0;
    exp_col = 0;
    exp_dur = MEM;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [18:0] e;
    if (chk_en && rst_n) begin
      if (buf_we) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr=%0d data=%0h", buf_addr, buf_wdata);
        end else begin
          e = expq.pop_front();
          chk("write_addr_data", int'({buf_addr, buf_wdata}), int'(e));
        end
      end
      chk("in_ready", int'(in_ready), int'(!busy && !clear_req));
      if (!busy) begin
        chk("idle_cursor", int'(cursor_row) * 1000 + int'(cursor_col), exp_row * 1000 + exp_col);
        chk("idle_addr", int'(buf_addr), exp_row * COLS + exp_col);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic fin();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic send_start(input logic [6:0] ch);
    int n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 10000) begin
        chk("ready_timeout", 0, 1);
        fin();
      end
    end
    #1;
    in_valid = 1'b1;
    in_char  = ch;
    @(posedge clk);
    model_accept(ch);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 6000) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, n, exp_dur);
  endtask

  task automatic send(input logic [6:0] ch);
    int n;
    send_start(ch);
    wait_done("char", n);
  endtask

  task automatic do_clear(input logic [6:0] ch, output int n);
    #1;
    clear_req = 1'b1;
    in_valid  = 1'b1;
    in_char   = ch;
    #1 chk("clear_blocks_ready", int'(in_ready), 0);
    @(posedge clk);
    model_clear();
    #1;
    clear_req = 1'b0;
    in_valid  = 1'b0;
    wait_done("clear", n);
  endtask

  task automatic chk_mem(input string name);
    int diffs = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk(name, diffs, 0);
  endtask

  function automatic logic [6:0] rnd_print();
    return 7'($urandom_range(32, 126));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [6:0] c;
    for (int i = 0; i < MEM; i++) ref_mem[i] = 7'd0;

    repeat (3) @(negedge clk);
    chk("rst_buf_we", int'(buf_we), 0);
    chk("rst_buf_addr", int'(buf_addr), 0);
    chk("rst_buf_wdata", int'(buf_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cursor", int'(cursor_row) * 1000 + int'(cursor_col), 0);

    // First character on the first edge after reset release.
    #1;
    rst_n    = 1'b1;
    chk_en   = 1'b1;
    in_valid = 1'b1;
    in_char  = 7'h41;
    @(posedge clk);
    model_accept(7'h41);
    #1 in_valid = 1'b0;
    chk("A_we", int'(buf_we), 1);
    chk("A_addr", int'(buf_addr), 0);
    chk("A_wdata", int'(buf_wdata), 8'h41);
    chk("A_cursor", int'(cursor_row) * 1000 + int'(cursor_col), 1);
    chk("A_ready_low", int'(in_ready), 0);
    @(posedge clk);
    #1 chk("A_ready_back", int'(in_ready), 1);
    @(negedge clk);

    // Clear wins over a simultaneous character.
    do_clear(7'h51, n);
    chk("clear_cycles", n, 2400);
    chk("clear_mem0", int'(mem[0]), 8'h20);
    chk("clear_mem_last", int'(mem[MEM-1]), 8'h20);
    chk_mem("clear_mem");

    // CR / LF / BS at column 0.
    do_clear(7'h00, n);
    repeat (5) send(7'h0A);
    repeat (10) send(rnd_print());
    chk("pos_5_10", int'(cursor_row) * 1000 + int'(cursor_col), 5010);
    send(7'h0D);
    chk("after_cr", int'(cursor_row) * 1000 + int'(cursor_col), 5000);
    send(7'h0A);
    chk("after_lf", int'(cursor_row) * 1000 + int'(cursor_col), 6000);
    send_start(7'h08);
    wait_done("bs_col0", n);
    chk("bs_col0_cycles", n, 0);
    chk("after_bs0", int'(cursor_row) * 1000 + int'(cursor_col), 6000);

    // Backspace erases at 3,3.
    do_clear(7'h00, n);
    repeat (3) send(7'h0A);
    repeat (4) send(7'h78);
    send(7'h08);
    chk("bs_mem243", int'(mem[243]), 8'h20);
    chk("bs_mem242", int'(mem[242]), 8'h78);
    chk("bs_cursor", int'(cursor_row) * 1000 + int'(cursor_col), 3003);

    // Wrap off the last row scrolls the screen.
    do_clear(7'h00, n);
    send(7'h0A);
    send(7'h23);
    repeat (28) send(7'h0A);
    repeat (79) send(rnd_print());
    chk("pos_29_79", int'(cursor_row) * 1000 + int'(cursor_col), 29079);
    send_start(7'h5A);
    wait_done("scroll", n);
    chk("scroll_cycles", n, 4721);
    chk("scroll_cursor", int'(cursor_row) * 1000 + int'(cursor_col), 29000);
    chk("scroll_row1_to_row0", int'(mem[0]), 8'h23);
    chk("scroll_Z_moved_up", int'(mem[2319]), 8'h5A);
    chk("scroll_blank_first", int'(mem[2320]), 8'h20);
    chk("scroll_blank_last", int'(mem[2399]), 8'h20);
    chk_mem("scroll_mem");

    // Randomised character stream.
    do_clear(7'h00, n);
    for (int k = 0; k < 150; k++) begin
      n = int'($urandom_range(0, 99));
      if (n < 70)      c = rnd_print();
      else if (n < 76) c = 7'h0A;
      else if (n < 82) c = 7'h0D;
      else if (n < 92) c = 7'h08;
      else begin
        c = 7'($urandom_range(0, 31));
        if (c == 7'h08 || c == 7'h0A || c == 7'h0D) c = 7'h7F;
      end
      send(c);
    end
    chk_mem("random_mem");

    // Reset in the middle of an LF-triggered scroll.
    do_clear(7'h00, n);
    repeat (29) send(7'h0A);
    send_start(7'h0A);
    n = 0;
    while (!(busy && !buf_we && buf_addr == 12'd1000) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_src1000", int'(n < 5000), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", int'(buf_we), 0);
    chk("arst_addr", int'(buf_addr), 0);
    chk("arst_wdata", int'(buf_wdata), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cursor", int'(cursor_row) * 1000 + int'(cursor_col), 0);
    expq.delete();
    for (int i = 0; i < MEM; i++) ref_mem[i] = mem[i];
    exp_row = 0;
    exp_col = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(7'h42);
    chk("after_rst_B", int'(mem[0]), 8'h42);
    chk("after_rst_cursor", int'(cursor_row) * 1000 + int'(cursor_col), 1);

    repeat (2) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    fin();
  end

endmodule

// File: doc/display_writer.md
DISPLAY_WRITER -- requirements
Module: display_writer

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter MEM_SIZE, default 2400, buffer depth; always equal to COLS*ROWS.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 in_valid  in  1  in_char holds a character code.
REQ-007 in_char  in  7  ASCII code to print or interpret.
REQ-008 in_ready  out  1  writer accepts in_char this cycle.
REQ-009 clear_req  in  1  level request to blank the screen and home the cursor.
REQ-010 buf_we  out  1  display buffer write enable.
REQ-011 buf_addr  out  12  display buffer address, row*COLS+col.
REQ-012 buf_wdata  out  7  display buffer write data.
REQ-013 buf_rdata  in  7  display buffer read data, valid one cycle after a buf_we=0 access.
REQ-014 cursor_row  out  5  current row, 0..ROWS-1.
REQ-015 cursor_col  out  7  current column, 0..COLS-1.
REQ-016 busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 The states SHALL be IDLE, WRITE, SCROLL_RD, SCROLL_WR, BLANK and CLEAR.
REQ-018 in_ready SHALL be combinational: IDLE & !clear_req.
REQ-019 A character SHALL be accepted on the rising edge where in_valid & in_ready.
REQ-020 Printable codes 0x20..0x7E SHALL cause WRITE on the next cycle: buf_we=1, buf_addr=cursor address, buf_wdata=in_char, then col+1.
REQ-021 Column wrap: a write at col COLS-1 SHALL set col=0 and row+1; at row ROWS-1 it SHALL instead keep row and enter SCROLL_RD.
REQ-022 0x0A (LF) SHALL set col=0 and row+1 without writing; at row ROWS-1 it SHALL enter SCROLL_RD directly from IDLE.
REQ-023 0x0D (CR) SHALL set col=0, no write, stay IDLE.
REQ-024 0x08 (BS) at col>0 SHALL decrement col and WRITE 0x20 at the new position; at col=0 it SHALL be a no-op.
REQ-025 All other codes SHALL be accepted and ignored.
REQ-026 Scroll source pointer src SHALL start at COLS.
REQ-027 SCROLL_RD SHALL drive buf_we=0, buf_addr=src.
REQ-028 SCROLL_WR SHALL drive buf_we=1, buf_addr=src-COLS, buf_wdata=buf_rdata, then src+1.
REQ-029 After the SCROLL_WR at src=MEM_SIZE-1, the block SHALL enter BLANK.
REQ-030 BLANK SHALL write 0x20 to addresses MEM_SIZE-COLS..MEM_SIZE-1, one per cycle, then return to IDLE.
REQ-031 A full scroll SHALL take 2*(MEM_SIZE-COLS)+COLS cycles (4720 at defaults); cursor stays at row ROWS-1, col 0.
REQ-032 clear_req high in IDLE SHALL win over a simultaneous in_valid (nothing accepted) and enter CLEAR.
REQ-033 CLEAR SHALL write 0x20 to addresses 0..MEM_SIZE-1 in ascending order, one per cycle, then set the cursor to 0,0 and return to IDLE.
REQ-034 clear_req outside IDLE SHALL be ignored until IDLE.
REQ-035 In IDLE: buf_we=0, buf_addr=cursor address.
REQ-036 Cursor address SHALL be computed as (row<<6)+(row<<4)+col at 12 bits, never exceeding MEM_SIZE-1.
REQ-037 buf_we, buf_addr and buf_wdata SHALL be registered outputs.

Reset
REQ-038 On rst_n low: state=IDLE, cursor 0,0, src=COLS, buf_we=0, buf_addr=0, buf_wdata=0, busy=0.
REQ-039 Reset mid-scroll or mid-clear SHALL abort immediately; the buffer remains partially updated and no completion is attempted.
REQ-040 The first character SHALL be accepted on the first rising edge after rst_n goes high.

Verification
REQ-041 Reset, send 'A' (0x41) -> one cycle later buf_we=1, addr 0, wdata 0x41; cursor 0,1; in_ready low for exactly one cycle.
REQ-042 Cursor at 29,79, send 'Z' -> write at addr 2399, then 4720 scroll cycles (row 1 moves to row 0, row 29 becomes 0x20); cursor ends at 29,0; busy drops.
REQ-043 Cursor 5,10, send 0x0D, 0x0A, 0x08 -> cursor 5,0, then 6,0, then 6,0 with no write.
REQ-044 Cursor 3,4, send 0x08 -> write 0x20 at addr 243; cursor 3,3.
REQ-045 Assert clear_req together with in_valid in IDLE -> char not accepted; 2400 writes of 0x20 at addrs 0..2399; cursor 0,0.
REQ-046 Drop rst_n at src=1000 during a scroll -> outputs go to reset values immediately; the next 'B' writes at addr 0.
